// File: rtl/npu_spm_defines.sv
// Shared scratchpad-memory geometry and the lane-level field types used
// throughout the SPM pipeline.
`ifndef NPU_SPM_DEFINES_SV
`define NPU_SPM_DEFINES_SV

`define SM_PROCESSING_ELEMENTS 16
`define SM_MEMORY_BANKS 16

package npu_spm_defines;

   typedef logic [$clog2(`SM_MEMORY_BANKS)-1:0] sm_bank_address_t;
   typedef logic [9:0]                          sm_entry_address_t;
   typedef logic [31:0]                         sm_data_t;

endpackage

`endif

// File: rtl/spm_bank_conflict_serializer_pkg.sv
// Helpers shared by the bank-conflict serializer and its arbiter.
package spm_bank_conflict_serializer_pkg;

   // Batch counter width: a request never needs more than one batch per lane.
   function automatic int batch_idx_width(input int num_lanes);
      return $clog2(num_lanes) + 1;
   endfunction

endpackage

// File: rtl/spm_bank_conflict_arbiter.sv
// Combinational grant logic: picks one conflict-free batch out of the
// still-pending lanes of the captured request.
module spm_bank_conflict_arbiter
   import npu_spm_defines::*;
#(
   parameter int NUM_LANES = `SM_PROCESSING_ELEMENTS
) (
   input  logic [NUM_LANES-1:0] pending,
   input  sm_bank_address_t     bank_indexes [NUM_LANES],
   input  sm_entry_address_t    bank_offsets [NUM_LANES],
   input  logic                 is_store,
   output logic [NUM_LANES-1:0] grant,
   output logic                 last
);

   // A lane with w_has_lower_leader set is not the leader of its bank;
   // w_leader_offset then holds the offset the leader is accessing.
   logic              w_has_lower_leader [NUM_LANES];
   sm_entry_address_t w_leader_offset    [NUM_LANES];

   // Priority scan over lower lanes: first pending lane on the same bank wins.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch so
      // no path leaves it unassigned, which would infer a latch.
      for (int i = 0; i < NUM_LANES; i++) begin
         w_has_lower_leader[i] = 1'b0;
         w_leader_offset[i]    = bank_offsets[i];
      end
      for (int i = 0; i < NUM_LANES; i++) begin
         for (int j = 0; j < i; j++) begin
            if (!w_has_lower_leader[i] && pending[j] &&
                (bank_indexes[j] == bank_indexes[i])) begin
               w_has_lower_leader[i] = 1'b1;
               w_leader_offset[i]    = bank_offsets[j];
            end
         end
      end
   end

   // Leaders always go; loads also broadcast to lanes hitting the leader's entry.
   always_comb begin
      grant = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         grant[i] = pending[i] &&
                    (!w_has_lower_leader[i] ||
                     (!is_store && (bank_offsets[i] == w_leader_offset[i])));
      end
      last = ((pending & ~grant) == '0);
   end

endmodule

// File: rtl/spm_bank_conflict_serializer.sv
// Splits one warp-wide SPM request into bank-conflict-free batches and
// streams them to the bank array one per cycle over valid/ready.
module spm_bank_conflict_serializer
   import npu_spm_defines::*;
   import spm_bank_conflict_serializer_pkg::*;
#(
   parameter int NUM_LANES = `SM_PROCESSING_ELEMENTS,
   parameter int NUM_BANKS = `SM_MEMORY_BANKS
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic                                 in_is_store,
   input  logic [NUM_LANES-1:0]                 in_mask,
   input  sm_bank_address_t                     in_bank_indexes  [NUM_LANES],
   input  sm_entry_address_t                    in_bank_offsets  [NUM_LANES],
   input  sm_data_t                             in_write_data    [NUM_LANES],
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic                                 out_is_store,
   output logic [NUM_LANES-1:0]                 out_mask,
   output sm_bank_address_t                     out_bank_indexes [NUM_LANES],
   output sm_entry_address_t                    out_bank_offsets [NUM_LANES],
   output sm_data_t                             out_write_data   [NUM_LANES],
   output logic                                 out_last,
   output logic [batch_idx_width(NUM_LANES)-1:0] out_batch_idx
);

   localparam int IDX_W = batch_idx_width(NUM_LANES);

   // The bank index type must be able to name every bank.
   if (NUM_BANKS > (1 << $bits(sm_bank_address_t))) begin : g_bank_width_check
      $error("NUM_BANKS exceeds the range of sm_bank_address_t");
   end

   logic                 r_busy;
   logic [NUM_LANES-1:0] r_pending;
   logic                 r_is_store;
   sm_bank_address_t     r_bank_indexes [NUM_LANES];
   sm_entry_address_t    r_bank_offsets [NUM_LANES];
   sm_data_t             r_write_data   [NUM_LANES];
   logic [IDX_W-1:0]     r_batch_idx;

   logic [NUM_LANES-1:0] w_grant;
   logic                 w_last;
   logic                 w_accept;
   logic                 w_consume;

   spm_bank_conflict_arbiter #(
      .NUM_LANES (NUM_LANES)
   ) u_arbiter (
      .pending      (r_pending),
      .bank_indexes (r_bank_indexes),
      .bank_offsets (r_bank_offsets),
      .is_store     (r_is_store),
      .grant        (w_grant),
      .last         (w_last)
   );

   // A new request may enter while the final batch of the current one leaves.
   assign in_ready  = !r_busy || (out_ready && w_last);
   assign w_accept  = in_valid && in_ready;
   assign w_consume = r_busy && out_ready;

   // Capture on accept, otherwise retire the granted lanes on each consume.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_busy         <= 1'b0;
         r_pending      <= '0;
         r_is_store     <= 1'b0;
         r_batch_idx    <= '0;
         // NOTE: the captured lane fields are plain flops, not a RAM, so they
         // are reset too and the outputs read as zero after reset.
         r_bank_indexes <= '{default: '0};
         r_bank_offsets <= '{default: '0};
         r_write_data   <= '{default: '0};
      end else if (w_accept) begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         r_busy         <= 1'b1;
         r_pending      <= in_mask;
         r_is_store     <= in_is_store;
         r_batch_idx    <= '0;
         r_bank_indexes <= in_bank_indexes;
         r_bank_offsets <= in_bank_offsets;
         r_write_data   <= in_write_data;
      end else if (w_consume) begin
         r_pending   <= r_pending & ~w_grant;
         r_batch_idx <= r_batch_idx + IDX_W'(1);
         if (w_last) begin
            r_busy <= 1'b0;
         end
      end
   end

   assign out_valid        = r_busy;
   assign out_is_store     = r_is_store;
   assign out_mask         = w_grant;
   assign out_last         = w_last;
   assign out_batch_idx    = r_batch_idx;
   assign out_bank_indexes = r_bank_indexes;
   assign out_bank_offsets = r_bank_offsets;
   assign out_write_data   = r_write_data;

endmodule

// File: tb/tb_spm_bank_conflict_serializer.sv
// Self-checking bench for spm_bank_conflict_serializer: directed cases plus
// randomized traffic, compared against a per-bank grouping model.
module tb_spm_bank_conflict_serializer;
   import npu_spm_defines::*;

   localparam int L     = 16;
   localparam int IDX_W = $clog2(L) + 1;

   typedef struct {
      logic              is_store;
      logic [L-1:0]      mask;
      sm_bank_address_t  bank [L];
      sm_entry_address_t off  [L];
      sm_data_t          wd   [L];
   } req_t;

   typedef struct packed {
      logic [L-1:0]      mask;
      logic              last;
      logic [IDX_W-1:0]  idx;
      logic              is_store;
      sm_entry_address_t off0;
      sm_data_t          wd_top;
   } exp_t;

   logic              clk;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic              in_is_store;
   logic [L-1:0]      in_mask;
   sm_bank_address_t  in_bank_indexes  [L];
   sm_entry_address_t in_bank_offsets  [L];
   sm_data_t          in_write_data    [L];
   logic              out_valid;
   logic              out_ready;
   logic              out_is_store;
   logic [L-1:0]      out_mask;
   sm_bank_address_t  out_bank_indexes [L];
   sm_entry_address_t out_bank_offsets [L];
   sm_data_t          out_write_data   [L];
   logic              out_last;
   logic [IDX_W-1:0]  out_batch_idx;

   int   checks = 0;
   int   errors = 0;
   req_t req_q[$];
   exp_t exp_q[$];

   spm_bank_conflict_serializer #(
      .NUM_LANES (L),
      .NUM_BANKS (16)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_is_store      (in_is_store),
      .in_mask          (in_mask),
      .in_bank_indexes  (in_bank_indexes),
      .in_bank_offsets  (in_bank_offsets),
      .in_write_data    (in_write_data),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_is_store     (out_is_store),
      .out_mask         (out_mask),
      .out_bank_indexes (out_bank_indexes),
      .out_bank_offsets (out_bank_offsets),
      .out_write_data   (out_write_data),
      .out_last         (out_last),
      .out_batch_idx    (out_batch_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic req_t blank_req(input logic is_store);
      req_t r;
      r.is_store = is_store;
      r.mask     = '0;
      for (int i = 0; i < L; i++) begin
         r.bank[i] = '0;
         r.off[i]  = '0;
         r.wd[i]   = sm_data_t'($urandom);
      end
      return r;
   endfunction

   // Model: within each bank, accesses form groups (one group per lane for
   // stores, one group per distinct offset for loads, numbered in order of
   // first appearance). Batch n carries group n of every bank.
   function automatic void expect_batches(input req_t r);
      logic [L-1:0] masks [L];
      bit           first_of_off [L];
      int           group, first, nb;
      exp_t         e;
      nb = 1;
      for (int n = 0; n < L; n++) masks[n] = '0;
      for (int i = 0; i < L; i++) begin
         first_of_off[i] = 1'b0;
         if (!r.mask[i]) continue;
         group = 0;
         if (r.is_store) begin
            for (int j = 0; j < i; j++)
               if (r.mask[j] && r.bank[j] == r.bank[i]) group++;
         end else begin
            first = i;
            for (int j = i - 1; j >= 0; j--)
               if (r.mask[j] && r.bank[j] == r.bank[i] && r.off[j] == r.off[i]) first = j;
            first_of_off[i] = (first == i);
            for (int k = 0; k < first; k++)
               if (r.mask[k] && r.bank[k] == r.bank[i] && first_of_off[k]) group++;
         end
         masks[group][i] = 1'b1;
         if (group + 1 > nb) nb = group + 1;
      end
      for (int n = 0; n < nb; n++) begin
         e.mask     = masks[n];
         e.last     = (n == nb - 1);
         e.idx      = IDX_W'(n);
         e.is_store = r.is_store;
         e.off0     = r.off[0];
         e.wd_top   = r.wd[L-1];
         exp_q.push_back(e);
      end
   endfunction

   // Drives queued requests and checks every presented batch, one cycle per
   // iteration. mode 0: always ready, 1: random ready, 2: stall batch 0 for 3 cycles.
   task automatic run_phase(input int mode, input int limit, input bit must_drain);
      int   cyc = 0;
      int   stall_left;
      bit   accept, consume;
      req_t cur;
      exp_t head;
      stall_left = (mode == 2) ? 3 : 0;
      while ((req_q.size() != 0 || exp_q.size() != 0) && cyc < limit) begin
         if (req_q.size() != 0) begin
            cur         = req_q[0];
            in_valid    = 1'b1;
            in_is_store = cur.is_store;
            in_mask     = cur.mask;
            for (int i = 0; i < L; i++) begin
               in_bank_indexes[i] = cur.bank[i];
               in_bank_offsets[i] = cur.off[i];
               in_write_data[i]   = cur.wd[i];
            end
         end else begin
            in_valid = 1'b0;
         end
         case (mode)
            1:       out_ready = ($urandom_range(0, 3) != 0);
            2:       out_ready = (stall_left == 0);
            default: out_ready = 1'b1;
         endcase
         #1;
         check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            head = exp_q[0];
            check("out_mask", 64'(out_mask), 64'(head.mask));
            check("out_last", 64'(out_last), 64'(head.last));
            check("out_batch_idx", 64'(out_batch_idx), 64'(head.idx));
            check("out_is_store", 64'(out_is_store), 64'(head.is_store));
            check("out_offset0", 64'(out_bank_offsets[0]), 64'(head.off0));
            check("out_wdata_top", 64'(out_write_data[L-1]), 64'(head.wd_top));
            check("in_ready_busy", 64'(in_ready), 64'(out_ready && head.last));
            if (stall_left > 0) stall_left--;
         end else begin
            check("in_ready_idle", 64'(in_ready), 64'(1));
         end
         consume = (exp_q.size() != 0) && out_ready;
         accept  = in_valid && in_ready;
         @(posedge clk);
         if (consume) void'(exp_q.pop_front());
         if (accept) expect_batches(req_q.pop_front());
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      if (must_drain) check("drain_timeout", 64'(cyc < limit), 64'(1));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
      check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
      check({tag, "_out_mask"}, 64'(out_mask), 64'(0));
      check({tag, "_out_last"}, 64'(out_last), 64'(1));
      check({tag, "_out_batch_idx"}, 64'(out_batch_idx), 64'(0));
      check({tag, "_out_offset0"}, 64'(out_bank_offsets[0]), 64'(0));
   endtask

   initial begin
      req_t r;
      reset       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      in_is_store = 1'b0;
      in_mask     = '0;
      for (int i = 0; i < L; i++) begin
         in_bank_indexes[i] = '0;
         in_bank_offsets[i] = '0;
         in_write_data[i]   = '0;
      end
      #1;
      check_reset_outputs("por");
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Load, lane i -> bank i, offset 0: single batch.
      r = blank_req(1'b0);
      r.mask = 16'hFFFF;
      for (int i = 0; i < L; i++) r.bank[i] = sm_bank_address_t'(i);
      req_q.push_back(r);
      run_phase(0, 100, 1'b1);

      // Load broadcast: all lanes bank 3 offset 5.
      r = blank_req(1'b0);
      r.mask = 16'hFFFF;
      for (int i = 0; i < L; i++) begin
         r.bank[i] = 4'd3;
         r.off[i]  = 10'd5;
      end
      req_q.push_back(r);
      run_phase(0, 100, 1'b1);

      // Same addresses as stores: 16 one-hot batches.
      r.is_store = 1'b1;
      req_q.push_back(r);
      run_phase(0, 100, 1'b1);

      // Load with one two-way bank conflict.
      r = blank_req(1'b0);
      r.mask    = 16'hFFFF;
      r.bank[0] = 4'd2;
      r.bank[1] = 4'd2;
      r.off[1]  = 10'd1;
      for (int i = 2; i < L; i++) r.bank[i] = sm_bank_address_t'((i < 3) ? 0 : i);
      r.bank[2] = 4'd0;
      req_q.push_back(r);
      run_phase(0, 100, 1'b1);

      // Stall batch 0, then two back-to-back requests behind it.
      req_q.push_back(r);
      r.is_store = 1'b1;
      r.mask     = 16'h00F3;
      req_q.push_back(r);
      r.is_store = 1'b0;
      r.mask     = 16'hFFFF;
      req_q.push_back(r);
      run_phase(2, 200, 1'b1);

      // Empty mask: exactly one empty, final batch.
      r = blank_req(1'b1);
      req_q.push_back(r);
      run_phase(0, 100, 1'b1);

      // Randomized traffic with random backpressure.
      for (int n = 0; n < 40; n++) begin
         r = blank_req(1'($urandom_range(0, 1)));
         r.mask = ($urandom_range(0, 7) == 0) ? '0 : L'($urandom);
         for (int i = 0; i < L; i++) begin
            r.bank[i] = sm_bank_address_t'($urandom_range(0, 3));
            r.off[i]  = sm_entry_address_t'($urandom_range(0, 2));
         end
         req_q.push_back(r);
      end
      run_phase(1, 5000, 1'b1);

      // Reset in the middle of a 16-batch store.
      r = blank_req(1'b1);
      r.mask = 16'hFFFF;
      for (int i = 0; i < L; i++) begin
         r.bank[i] = 4'd7;
         r.off[i]  = 10'd9;
      end
      req_q.push_back(r);
      run_phase(0, 4, 1'b0);
      check("midreq_busy_before_reset", 64'(out_valid), 64'(1));
      reset = 1'b0;
      #1;
      check_reset_outputs("midreq");
      req_q.delete();
      exp_q.delete();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Recovery after reset.
      r.is_store = 1'b0;
      req_q.push_back(r);
      run_phase(0, 100, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
